// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder. A start request in IDLE captures both operands.
// One sum bit is produced per cycle, LSB first, for WIDTH cycles. The result
// is then published on sum/carry, and done pulses for one cycle.
//
// Timing: start is accepted at edge N. The result is published on entry to
// DONE at edge N+WIDTH. done is high in the cycle that follows edge
// N+WIDTH+1. The FSM is already back in IDLE during that cycle, so a new start
// can be accepted while done is high. This gives one result every WIDTH+2
// cycles.
//
// Parameters
//   WIDTH   operand and sum width in bits (2..32)
//
// Ports
//   clk     sole clock, rising edge
//   rst     synchronous active-high reset
//   start   request an addition (accepted only in IDLE)
//   a, b    unsigned operands, captured on the accepting edge
//   busy    high while an addition is in progress (ADD and DONE states)
//   done    one-cycle pulse when sum/carry hold a new result
//   sum     (a + b) mod 2^WIDTH, held until the next result
//   carry   carry out of bit WIDTH-1
//   ovf     two's-complement overflow flag, present only when the macro
//           SERIAL_ADDER_OVF_EN is defined
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    // Holds the WIDTH-1 sum bits produced so far. The oldest bit sits at
    // index 0. The final bit is merged directly into sum.
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    // Operand sign bits, kept because the operand registers shift them out.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic             bit_s;
    logic             cout_s;
    logic [WIDTH-1:0] merged_s;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        // Full adder on the current LSBs.
        bit_s    = opa_q[0] ^ opb_q[0] ^ c_q;
        cout_s   = (opa_q[0] & opb_q[0]) | (c_q & (opa_q[0] ^ opb_q[0]));
        // New bit at the MSB end, on top of the bits collected so far.
        // On the last step this value is the complete sum.
        merged_s = {bit_s, acc_q};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                acc_d = merged_s[WIDTH-1:1];
                c_d   = cout_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish the result on entry to DONE.
                    sum_d   = merged_s;
                    carry_d = cout_s;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
`endif
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only. Every flop
    // updates from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register is cleared here, including the datapath.
            // No stale operands or partial sums survive a reset.
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH = 8). The expected results come
// from a plain arithmetic model (a + b, overflow computed from sign bits).
// Inputs are driven on the falling edge, and outputs are sampled there as well.
// When SERIAL_ADDER_OVF_EN is defined, the ovf port is also checked.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state: the last published result.
    logic [W-1:0] exp_sum   = '0;
    logic         exp_carry = 1'b0;
    logic         exp_ovf   = 1'b0;
    int           done_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y};
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The caller must be at a falling edge with the DUT in IDLE.
    // inj_at >= 0 re-asserts start with other operands, one cycle at that
    // offset, while the addition is in flight.
    // The task returns at the falling edge where done is high.
    task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input int inj_at);
        logic [W:0] r;
        int         lat;
        r     = ref_add(xa, xb);
        lat   = -1;
        start = 1'b1;
        a     = xa;
        b     = xb;
        @(posedge clk);                      // accepting edge N
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);                  // after edge N+i
            if (i == inj_at) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
            end else begin
                start = 1'b0;
                a     = 8'($urandom);
                b     = 8'($urandom);
            end
            if (done) begin
                lat = i;
                break;
            end
            check("busy_in_flight", {31'd0, busy}, 32'd1);
            if (i <= W - 1) begin
                check("sum_held", {24'd0, sum}, {24'd0, exp_sum});
                check("carry_held", {31'd0, carry}, {31'd0, exp_carry});
            end
        end
        if (lat < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", lat, W + 1);
            check("sum", {24'd0, sum}, {24'd0, r[W-1:0]});
            check("carry", {31'd0, carry}, {31'd0, r[W]});
            check("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", {31'd0, ovf}, {31'd0, ref_ovf(xa, xb)});
`endif
        end
        exp_sum   = r[W-1:0];
        exp_carry = r[W];
        exp_ovf   = ref_ovf(xa, xb);
        done_cyc  = cyc;
    endtask

    task automatic no_more_done(input int n);
        int pulses;
        pulses = 0;
        start  = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("extra_done", pulses, 0);
        check("sum_stable", {24'd0, sum}, {24'd0, exp_sum});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t1;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        idle(2);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        idle(1);

        // Directed corner cases.
        run_add(8'h00, 8'h00, -1);
        idle(2);
        run_add(8'hFF, 8'h01, -1);
        idle(1);
        run_add(8'hA5, 8'h5A, -1);
        idle(1);

        // start while busy: once mid-ADD, once in DONE.
        run_add(8'h03, 8'h04, 2);
        no_more_done(12);
        run_add(8'h05, 8'h06, W);
        no_more_done(12);

        // Reset 4 cycles into an addition (sum currently 0B, not zero).
        start = 1'b1;
        a     = 8'h37;
        b     = 8'h29;
        @(posedge clk);                      // accepting edge N
        @(negedge clk);
        start = 1'b0;
        idle(3);
        rst = 1'b1;                          // sampled at edge N+4
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_carry", {31'd0, carry}, 32'd0);
        rst       = 1'b0;
        exp_sum   = '0;
        exp_carry = 1'b0;
        exp_ovf   = 1'b0;
        no_more_done(15);

        // Overflow vectors (ovf is checked only when the port exists).
        run_add(8'h7F, 8'h01, -1);
        idle(1);
        run_add(8'hFF, 8'hFF, -1);
        idle(1);

        // Back-to-back: the second start is raised in the done cycle.
        run_add(8'h01, 8'h01, -1);
        t1 = done_cyc;
        run_add(8'h80, 8'h80, -1);
        check("b2b_spacing", done_cyc - t1, W + 2);
        start = 1'b0;
        idle(1);

        // Random operands with random idle gaps.
        for (int k = 0; k < 20; k++) begin
            run_add(8'($urandom), 8'($urandom), -1);
            start = 1'b0;
            idle(int'($urandom_range(0, 2)));
        end
        no_more_done(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: start  input  1  request to begin an addition; sampled on a rising edge.
REQ-005 SHALL provide port: a  input  WIDTH  first operand, unsigned; captured when start is accepted.
REQ-006 SHALL provide port: b  input  WIDTH  second operand, unsigned; captured when start is accepted.
REQ-007 SHALL provide port: busy  output  1  high while an addition is in progress.
REQ-008 SHALL provide port: done  output  1  single-cycle pulse when sum and carry become valid.
REQ-009 SHALL provide port: sum  output  WIDTH  result (a+b) mod 2^WIDTH.
REQ-010 SHALL provide port: carry  output  1  carry out of bit WIDTH-1.

Function
REQ-011 SHALL implement an FSM with states IDLE, ADD and DONE; IDLE is the reset state.
REQ-012 SHALL, in IDLE with start=1, capture a and b into shift registers, clear the carry register and bit counter, and enter ADD on the same edge.
REQ-013 SHALL, each ADD cycle, compute one bit LSB-first as opA[0]^opB[0]^c with next carry (opA[0]&opB[0])|(c&(opA[0]^opB[0])), shift both operands right, and shift the sum bit into the sum register from the MSB end.
REQ-014 SHALL remain in ADD for exactly WIDTH cycles, then enter DONE.
REQ-015 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-016 SHALL give fixed latency: start accepted at edge N -> done high during the cycle following edge N+WIDTH+1.
REQ-017 SHALL drive busy high in ADD and DONE and low in IDLE.
REQ-018 SHALL ignore start in ADD and DONE; captured operands and the in-flight result SHALL stay unaffected.
REQ-019 SHALL update sum and carry only on the transition into DONE, and hold them stable until the next such transition; partial results SHALL NOT be visible on sum.
REQ-020 SHALL accept a start asserted in the first IDLE cycle after DONE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-021 SHALL NOT register changes on a or b outside the accepting edge.

Reset
REQ-022 SHALL, with rst=1 at a rising edge, force state to IDLE, and busy, done, sum, carry and all internal registers to 0, regardless of state.
REQ-023 SHALL let rst take priority over start on the same edge; an addition in progress SHALL be abandoned without asserting done.

Configuration
REQ-024 SHALL recognise the macro SERIAL_ADDER_OVF_EN.
REQ-025 SHALL, when SERIAL_ADDER_OVF_EN is defined, add port ovf (output, 1): two's-complement overflow flag, equal to (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), updated and held with sum, reset to 0.
REQ-026 SHALL, when SERIAL_ADDER_OVF_EN is undefined, omit the ovf port and its logic, with all other behaviour identical.

Verification
REQ-027 SHALL cover: WIDTH=8, a=8'h00, b=8'h00, start pulse -> done 9 cycles after the accepting edge, sum=8'h00, carry=0.
REQ-028 SHALL cover: a=8'hFF, b=8'h01 -> sum=8'h00, carry=1; a=8'hA5, b=8'h5A -> sum=8'hFF, carry=0.
REQ-029 SHALL cover: start re-asserted with a=8'h11, b=8'h22 while busy on 8'h03+8'h04 -> sum=8'h07, and no second done follows.
REQ-030 SHALL cover: rst asserted 4 cycles into an addition -> next cycle busy=0, done=0, sum=8'h00, carry=0, with no done pulse.
REQ-031 SHALL cover: with SERIAL_ADDER_OVF_EN defined, a=8'h7F, b=8'h01 -> sum=8'h80, carry=0, ovf=1; a=8'hFF, b=8'hFF -> sum=8'hFE, carry=1, ovf=0.
REQ-032 SHALL cover: back-to-back starts, 8'h01+8'h01 then 8'h80+8'h80 -> done pulses exactly 10 cycles apart, results 8'h02/carry 0 then 8'h00/carry 1.
